chess_clock_referee: RTL
========================

# chess_clock_referee

Game controller for the two-player chess clock. Consumes each player's click (`o_turn`) and flag (`o_zero`) outputs and drives their `i_stop`, `i_win` and `i_init` inputs. It also drives a player-reset pulse that reloads the players' countdown counters. It sequences one game: preset, load, waiting, alternating play, pause and game over. It also keeps a two-digit BCD half-move count for display.

## Interface
Parameters:
- `p_init_default`, 8'h05 — BCD preset (tens, units) used after reset.
- `p_rst_len`, 4 — length of the player-reset pulse in cycles; legal range 1..15.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  single-cycle click from the referee button driver.
- `i_init`  in  [3:0] x2  BCD preset: [1] tens, [0] units.
- `i_turn`  in  [1:0]  click pulses; bit 0 = player A, bit 1 = player B.
- `i_zero`  in  [1:0]  player counter-at-zero flags.
- `o_init`  out  [3:0] x2  latched preset, fanned out to both players.
- `o_prst`  out  1  active-low player reset.
- `o_stop`  out  [1:0]  per-player clock stop.
- `o_win`  out  [1:0]  per-player win flag.
- `o_moves`  out  [3:0] x2  BCD half-move count.
- `o_state`  out  3  encoded FSM state, for debug and LEDs.

## Operation
States:
- **IDLE**
  - Clocks stopped.
  - On `i_start`: sanitise `i_init` (any digit >9 clamps to 9).
  - If the sanitised preset is 00, ignore the start and stay in IDLE.
  - Otherwise latch the preset into `o_init`, clear `o_moves` and go to LOAD.
- **LOAD**
  - `o_prst`=0 for `p_rst_len` cycles, then go to READY.
  - `i_zero`, `i_turn` and `i_start` are ignored.
- **READY**
  - Both clocks stopped.
  - `i_turn`=01: go to RUN_B.
  - `i_turn`=10: go to RUN_A.
  - `i_turn`=11: ignore.
  - `i_zero` is ignored in READY.
- **RUN_A** (A's clock runs; `o_stop`=2'b10)
  - `i_zero[0]`: go to OVER with `o_win`=2'b10. This has priority over any same-cycle turn or start.
  - Else `i_turn[0]`: go to RUN_B and increment moves.
  - Else `i_start`: go to PAUSE, remembering side A.
  - `i_turn[1]` is ignored.
- **RUN_B**: mirror of RUN_A (`o_stop`=2'b01, `i_zero[1]` gives `o_win`=2'b01).
- **PAUSE**
  - Both stopped.
  - `i_start` returns to the remembered RUN state.
  - Turns and zero flags are ignored.
- **OVER**
  - Both stopped; `o_win` held.
  - `i_start` clears `o_win` and goes to IDLE. `o_moves` and `o_init` are kept.

Moves counter:
- BCD, 00..99; wraps 99→00.
- Increments only on an accepted handover.

## Timing
- Reset values:
  - state IDLE
  - `o_stop`=2'b11
  - `o_win`=2'b00
  - `o_prst`=1
  - `o_init`=`p_init_default`
  - `o_moves`=00
- All outputs are registered. State, `o_stop`, `o_win` and `o_moves` update on the clock edge that samples the event, so they are visible one cycle after the input pulse.
- `o_prst` goes low on the edge entering LOAD and stays low for exactly `p_rst_len` cycles. READY is entered on the edge that releases it.
- `i_turn` and `i_start` are single-cycle pulses. A pulse held high across multiple cycles counts once per cycle; single-cycle pulses are the driver's responsibility.
- `i_zero` is a level.
- In RUN_x, the zero check applies only to the running side. A stale zero on the stopped side is ignored.
- Async reset mid-game returns to IDLE immediately. Players are not reset by this block in that case; they share `i_rst` at top level.

## Structure
- Package `chess_clock_pkg` holds:
  - state enum: IDLE, LOAD, READY, RUN_A, RUN_B, PAUSE, OVER, with 3-bit encoding fixed in the package
  - player index constants `PL_A`=0, `PL_B`=1
  - BCD digit type `bcd_t` [3:0]
  - clamp function `bcd_sat`
- One sub-module: the existing `counter_dec_2w` reused as the moves counter. It is driven through `i_plus`, with a clear on LOAD.
- FSM and LOAD-length counter live in this block.

## Test plan
- Reset, then `i_init`=1,5 with `i_start` → `o_init`=1,5; `o_prst` low for 4 cycles; READY; `o_stop`=11.
- READY, `i_turn`=10 → RUN_A, `o_stop`=10. Then `i_turn[1]` → no change. Then `i_turn[0]` → RUN_B, `o_stop`=01, `o_moves`=01.
- RUN_A with `i_turn[0]` and `i_zero[0]` in the same cycle → OVER, `o_win`=10, `o_moves` unchanged. Then `i_start` → IDLE, `o_win`=00.
- RUN_B, `i_start` → PAUSE, `o_stop`=11. `i_turn` and `i_zero[1]` are ignored. `i_start` → RUN_B.
- 100 alternating handovers → `o_moves` goes 99 then 00.
- `i_init`=0,0 with `i_start` → stays IDLE. `i_init`=C,3 → `o_init`=9,3.

Source files
------------

// File: rtl/chess_clock_pkg.sv
// Shared types and helpers for the chess clock referee: state encoding,
// player indices and BCD digit handling.
package chess_clock_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READY = 3'd2,
    RUN_A = 3'd3,
    RUN_B = 3'd4,
    PAUSE = 3'd5,
    OVER  = 3'd6
  } state_t;

  localparam int PL_A = 0;
  localparam int PL_B = 1;

  typedef logic [3:0] bcd_t;

  // Out-of-range BCD digits from the preset switches saturate at 9.
  function automatic bcd_t bcd_sat(input bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/counter_dec_2w.sv
// Two-digit BCD up-counter, 00..99 wrapping to 00, with synchronous clear.
module counter_dec_2w
  import chess_clock_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_plus,
  output bcd_t [1:0] o_count
);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= '0;
    end else if (i_plus) begin
      if (o_count[0] == 4'd9) begin
        o_count[0] <= 4'd0;
        o_count[1] <= (o_count[1] == 4'd9) ? 4'd0 : o_count[1] + 4'd1;
      end else begin
        o_count[0] <= o_count[0] + 4'd1;
      end
    end
  end

endmodule

// File: rtl/chess_clock_referee.sv
// Game sequencer for the two-player chess clock: preset latch, player reset
// pulse, alternating play, pause, game over and a BCD half-move count.
module chess_clock_referee
  import chess_clock_pkg::*;
#(
  parameter logic [7:0] p_init_default = 8'h05,
  parameter int         p_rst_len      = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  bcd_t [1:0] i_init,
  input  logic [1:0] i_turn,
  input  logic [1:0] i_zero,
  output bcd_t [1:0] o_init,
  output logic       o_prst,
  output logic [1:0] o_stop,
  output logic [1:0] o_win,
  output bcd_t [1:0] o_moves,
  output logic [2:0] o_state
);

  localparam logic [3:0] RST_LAST = 4'(p_rst_len - 1);

  // Handshake: i_start and i_turn are one-cycle pulses, each high cycle is one
  // event; i_zero is a level. Every output is registered and reflects the event
  // on the edge that samples it.
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  bcd_t [1:0] init_q, init_d;
  logic [1:0] stop_q, stop_d;
  logic [1:0] win_q, win_d;
  logic       prst_q, prst_d;
  logic       side_q, side_d;  // 0: pause came from RUN_A, 1: from RUN_B
  bcd_t [1:0] san;
  logic       mv_clr, mv_plus;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_d  = init_q;
    win_d   = win_q;
    prst_d  = prst_q;
    side_d  = side_q;
    mv_clr  = 1'b0;
    mv_plus = 1'b0;
    san[1]  = bcd_sat(i_init[1]);
    san[0]  = bcd_sat(i_init[0]);

    case (state_q)
      IDLE: begin
        if (i_start && san != '0) begin
          state_d = LOAD;
          init_d  = san;
          mv_clr  = 1'b1;
          prst_d  = 1'b0;
          cnt_d   = RST_LAST;
        end
      end
      LOAD: begin
        if (cnt_q == 4'd0) begin
          state_d = READY;
          prst_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READY: begin
        if (i_turn == 2'b01)      state_d = RUN_B;
        else if (i_turn == 2'b10) state_d = RUN_A;
      end
      RUN_A: begin
        if (i_zero[PL_A]) begin
          state_d     = OVER;
          win_d[PL_B] = 1'b1;
        end else if (i_turn[PL_A]) begin
          state_d = RUN_B;
          mv_plus = 1'b1;
        end else if (i_start) begin
          state_d = PAUSE;
          side_d  = 1'b0;
        end
      end
      RUN_B: begin
        if (i_zero[PL_B]) begin
          state_d     = OVER;
          win_d[PL_A] = 1'b1;
        end else if (i_turn[PL_B]) begin
          state_d = RUN_A;
          mv_plus = 1'b1;
        end else if (i_start) begin
          state_d = PAUSE;
          side_d  = 1'b1;
        end
      end
      PAUSE: begin
        if (i_start) state_d = side_q ? RUN_B : RUN_A;
      end
      OVER: begin
        if (i_start) begin
          state_d = IDLE;
          win_d   = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase

    // Only the running side's clock is released; every other state stops both.
    case (state_d)
      RUN_A:   stop_d = 2'b10;
      RUN_B:   stop_d = 2'b01;
      default: stop_d = 2'b11;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      init_q  <= p_init_default;
      stop_q  <= 2'b11;
      win_q   <= 2'b00;
      prst_q  <= 1'b1;
      side_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      stop_q  <= stop_d;
      win_q   <= win_d;
      prst_q  <= prst_d;
      side_q  <= side_d;
    end
  end

  counter_dec_2w u_moves (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (mv_clr),
    .i_plus  (mv_plus),
    .o_count (o_moves)
  );

  assign o_init  = init_q;
  assign o_stop  = stop_q;
  assign o_win   = win_q;
  assign o_prst  = prst_q;
  assign o_state = state_q;

endmodule
